// File: rtl/neuron_pkg.sv
// Shared sizing, config address map and clamp helper for the LIF neuron.
package neuron_pkg;

  localparam int CFG_THRESH = 0;
  localparam int CFG_REFRAC = 1;

  function automatic int acc_w(int state_w, int in_w, int w_w, int n_in);
    return state_w + in_w + w_w + $clog2(n_in) + 2;
  endfunction

  // Clamp a signed accumulator into the unsigned range [0, 2^state_w-1].
  function automatic logic [63:0] saturate_u(logic signed [63:0] v, int state_w);
    logic signed [63:0] max_v;
    max_v = (64'sd1 <<< state_w) - 64'sd1;
    if (v < 64'sd0) return '0;
    if (v > max_v) return max_v;
    return v;
  endfunction

endpackage

// File: rtl/neuron_weighted_sum.sv
// Combinational dot product of unsigned inputs with signed weights.
module neuron_weighted_sum #(
  parameter int N_IN  = 2,
  parameter int IN_W  = 4,
  parameter int W_W   = 4,
  parameter int ACC_W = 19
) (
  input  logic [N_IN*IN_W-1:0]     x_i,
  input  logic [N_IN*W_W-1:0]      w_i,
  output logic signed [ACC_W-1:0]  sum_o
);

  logic [N_IN-1:0][ACC_W-1:0] prod;

  for (genvar i = 0; i < N_IN; i++) begin : g_mac
    logic signed [ACC_W-1:0] xe, we;
    assign xe      = ACC_W'($signed({1'b0, x_i[i*IN_W +: IN_W]}));
    assign we      = ACC_W'($signed(w_i[i*W_W +: W_W]));
    assign prod[i] = xe * we;
  end

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < N_IN; i++) sum_o = sum_o + $signed(prod[i]);
  end

endmodule

// File: rtl/lif_perceptron_n.sv
// Leaky integrate-and-fire neuron: config regfile, leak, saturation,
// threshold compare and refractory hold.
module lif_perceptron_n
  import neuron_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int IN_W       = 4,
  parameter int W_W        = 4,
  parameter int STATE_W    = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC_DEF = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [N_IN*IN_W-1:0]          v_in,
  input  logic                          cfg_we,
  input  logic [$clog2(N_IN+2)-1:0]     cfg_addr,
  input  logic [STATE_W-1:0]            cfg_data,
  output logic [STATE_W-1:0]            state,
  output logic                          v_out,
  output logic                          refractory
);

  localparam int ACC_W = acc_w(STATE_W, IN_W, W_W, N_IN);
  localparam int AW    = $clog2(N_IN+2);

  localparam logic ST_INTEGRATE  = 1'b0;
  localparam logic ST_REFRACTORY = 1'b1;

  logic [N_IN-1:0][W_W-1:0] w_q, w_d;
  logic [STATE_W-1:0]       thr_q, thr_d, per_q, per_d, cnt_q, cnt_d;
  logic [STATE_W-1:0]       state_q, state_d;
  logic                     spike_q, spike_d;
  logic                     mode;

  logic signed [ACC_W-1:0]  sum, st_ext, leak, nxt;
  logic [STATE_W-1:0]       sat;

  neuron_weighted_sum #(
    .N_IN (N_IN),
    .IN_W (IN_W),
    .W_W  (W_W),
    .ACC_W(ACC_W)
  ) u_wsum (
    .x_i  (v_in),
    .w_i  (w_q),
    .sum_o(sum)
  );

  assign st_ext = ACC_W'(state_q);
  assign leak   = ACC_W'(state_q >> LEAK_SHIFT);
  assign nxt    = st_ext - leak + sum;
  assign sat    = STATE_W'(saturate_u(64'(nxt), STATE_W));
  assign mode   = (cnt_q != '0) ? ST_REFRACTORY : ST_INTEGRATE;

  always_comb begin
    w_d     = w_q;
    thr_d   = thr_q;
    per_d   = per_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    spike_d = 1'b0;
    // The step below reads only _q values, so a same-cycle write lands next edge.
    if (cfg_we) begin
      for (int i = 0; i < N_IN; i++)
        if (cfg_addr == AW'(i)) w_d[i] = cfg_data[W_W-1:0];
      if (cfg_addr == AW'(N_IN + CFG_THRESH)) thr_d = cfg_data;
      if (cfg_addr == AW'(N_IN + CFG_REFRAC)) per_d = cfg_data;
    end
    if (en) begin
      case (mode)
        ST_REFRACTORY: begin
          cnt_d   = cnt_q - 1'b1;
          state_d = '0;
        end
        default: begin
          if (sat >= thr_q) begin
            state_d = '0;
            spike_d = 1'b1;
            cnt_d   = per_q;
          end else begin
            state_d = sat;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) w_q[i] <= W_W'(1);
      thr_q   <= STATE_W'(1) << (STATE_W-1);
      per_q   <= STATE_W'(REFRAC_DEF);
      cnt_q   <= '0;
      state_q <= '0;
      spike_q <= 1'b0;
    end else begin
      w_q     <= w_d;
      thr_q   <= thr_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      spike_q <= spike_d;
    end
  end

  assign state      = state_q;
  assign v_out      = spike_q;
  assign refractory = (cnt_q != '0);

endmodule

// File: tb/tb_lif_perceptron_n.sv
// Directed bench for lif_perceptron_n with an integer-arithmetic reference model.
module tb_lif_perceptron_n;

  localparam int N_IN = 2, IN_W = 4, W_W = 4, STATE_W = 8, LEAK_SHIFT = 1, REFRAC_DEF = 2;
  localparam int AW = $clog2(N_IN+2);

  logic                  clk = 1'b0;
  logic                  reset, en, cfg_we;
  logic [N_IN*IN_W-1:0]  v_in;
  logic [AW-1:0]         cfg_addr;
  logic [STATE_W-1:0]    cfg_data;
  logic [STATE_W-1:0]    state;
  logic                  v_out, refractory;

  int vecs = 0;
  int errs = 0;

  lif_perceptron_n #(
    .N_IN(N_IN), .IN_W(IN_W), .W_W(W_W), .STATE_W(STATE_W),
    .LEAK_SHIFT(LEAK_SHIFT), .REFRAC_DEF(REFRAC_DEF)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .v_in(v_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .state(state), .v_out(v_out), .refractory(refractory)
  );

  always #5 clk = ~clk;

  // Reference neuron in plain integers.
  int m_w [N_IN];
  int m_th, m_rp, m_cnt, m_st, m_sum, m_nx;
  bit m_vo, m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_IN; i++) m_w[i] = 1;
      m_th = 1 << (STATE_W-1); m_rp = REFRAC_DEF;
      m_cnt = 0; m_st = 0; m_vo = 0; m_valid = 1'b1;
    end else begin
      if (en) begin
        if (m_cnt > 0) begin
          m_cnt = m_cnt - 1; m_st = 0; m_vo = 0;
        end else begin
          m_sum = 0;
          for (int i = 0; i < N_IN; i++) m_sum += int'(v_in[i*IN_W +: IN_W]) * m_w[i];
          m_nx = m_st - (m_st >> LEAK_SHIFT) + m_sum;
          if (m_nx < 0) m_nx = 0;
          if (m_nx > (1 << STATE_W) - 1) m_nx = (1 << STATE_W) - 1;
          if (m_nx >= m_th) begin
            m_st = 0; m_vo = 1; m_cnt = m_rp;
          end else begin
            m_st = m_nx; m_vo = 0;
          end
        end
      end else m_vo = 0;
      if (cfg_we) begin
        if (int'(cfg_addr) < N_IN) m_w[cfg_addr] = int'($signed(cfg_data[W_W-1:0]));
        else if (int'(cfg_addr) == N_IN) m_th = int'(cfg_data);
        else if (int'(cfg_addr) == N_IN + 1) m_rp = int'(cfg_data);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      vecs++;
      if ({state, v_out, refractory} !== {STATE_W'(m_st), m_vo, (m_cnt != 0)}) begin
        errs++;
        $display("FAIL model t=%0t: got state=%0d v_out=%b refr=%b, expected state=%0d v_out=%b refr=%b",
                 $time, state, v_out, refractory, m_st, m_vo, (m_cnt != 0));
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(bit e, logic [7:0] v, bit we = 0, logic [AW-1:0] a = '0, logic [7:0] d = '0);
    en = e; v_in = v; cfg_we = we; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
  endtask

  int exp_s [7] = '{30, 45, 53, 57, 59, 60, 60};

  initial begin
    reset = 1'b1; en = 1'b1; v_in = 8'hFF; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_state", state, 0); chk("rst_vout", v_out, 0); chk("rst_refr", refractory, 0);
    end
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      cyc(1, 8'hFF); chk("leak_state", state, exp_s[i]); chk("leak_vout", v_out, 0);
    end
    cyc(0, 8'hFF, 1, 2, 50); chk("hold_state", state, 60);
    cyc(1, 8'hFF); chk("thr50_vout", v_out, 1); chk("thr50_state", state, 0); chk("thr50_refr", refractory, 1);
    cyc(1, 8'h00); chk("ref1", refractory, 1);
    cyc(1, 8'h00); chk("ref2", refractory, 0); chk("ref2_state", state, 0);

    cyc(0, 8'h00, 1, 0, 7); cyc(0, 8'h00, 1, 1, 7); cyc(0, 8'h00, 1, 2, 128);
    cyc(1, 8'hFF); chk("w7_s1_vout", v_out, 1); chk("w7_s1_state", state, 0);
    cyc(1, 8'hFF); chk("w7_s2_vout", v_out, 0); chk("w7_s2_refr", refractory, 1);
    cyc(1, 8'hFF); chk("w7_s3_refr", refractory, 0); chk("w7_s3_state", state, 0);
    cyc(1, 8'hFF); chk("w7_s4_vout", v_out, 1);
    cyc(0, 8'hFF); chk("tog_vout0", v_out, 0); chk("tog_refr0", refractory, 1);
    cyc(1, 8'hFF); chk("tog_refr1", refractory, 1);
    cyc(0, 8'hFF); chk("tog_refr2", refractory, 1);
    cyc(1, 8'hFF); chk("tog_refr3", refractory, 0); chk("tog_vout3", v_out, 0);
    cyc(0, 8'hFF); chk("tog_vout4", v_out, 0);
    cyc(1, 8'hFF); chk("tog_fire", v_out, 1);
    cyc(1, 8'h00); cyc(1, 8'h00); chk("drain_a", refractory, 0);

    cyc(0, 8'h00, 1, 0, 8'h08); cyc(0, 8'h00, 1, 1, 8'h08);
    repeat (3) begin
      cyc(1, 8'hFF); chk("neg_state", state, 0); chk("neg_vout", v_out, 0);
    end
    cyc(0, 8'h00, 1, 0, 7); cyc(0, 8'h00, 1, 1, 7); cyc(0, 8'h00, 1, 2, 255);
    cyc(1, 8'hFF); chk("t255_s1", state, 210); chk("t255_v1", v_out, 0);
    cyc(1, 8'hFF); chk("t255_fire", v_out, 1); chk("t255_s2", state, 0);
    cyc(1, 8'h00); cyc(1, 8'h00); chk("drain_b", refractory, 0);

    cyc(0, 8'h00, 1, 3, 0); cyc(0, 8'h00, 1, 2, 0);
    repeat (3) begin
      cyc(1, 8'h00); chk("t0_vout", v_out, 1); chk("t0_refr", refractory, 0);
    end
    cyc(1, 8'h00, 1, 2, 255); chk("old_thr_vout", v_out, 1);
    cyc(1, 8'h00); chk("new_thr_vout", v_out, 0); chk("new_thr_state", state, 0);

    cyc(0, 8'h00, 1, 3, 2); cyc(0, 8'h00, 1, 2, 0);
    cyc(1, 8'h00); chk("mid_fire", v_out, 1); chk("mid_refr", refractory, 1);
    reset = 1'b1;
    cyc(1, 8'hFF); chk("mid_rst_refr", refractory, 0); chk("mid_rst_state", state, 0); chk("mid_rst_vout", v_out, 0);
    reset = 1'b0;
    cyc(1, 8'hFF); chk("post_rst_state", state, 30); chk("post_rst_vout", v_out, 0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/lif_perceptron_n.md
Name: lif_perceptron_n

Overview:
Parametrised leaky integrate-and-fire perceptron, the successor to the fixed 2x4-bit perceptron.
- N_IN unsigned inputs, each multiplied by a runtime-programmable signed weight.
- Membrane state leaks by a shift each step; fires a one-cycle spike at a programmable threshold.
- After firing, holds a programmable refractory period.
- Sits directly under the tt_um top; ui_in/uio pins drive v_in and the config port, uo_out shows state.

Parameters:
- N_IN, 2, number of input channels
- IN_W, 4, width of each unsigned input
- W_W, 4, width of each signed two's-complement weight
- STATE_W, 8, membrane state / threshold width (unsigned)
- LEAK_SHIFT, 1, leak = state >> LEAK_SHIFT per step
- REFRAC_DEF, 2, reset value of refractory period (cycles), < 2^STATE_W

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- en  in  1  step enable; state advances only when 1
- v_in  in  N_IN*IN_W  packed inputs; channel i = v_in[i*IN_W +: IN_W]
- cfg_we  in  1  config write strobe
- cfg_addr  in  $clog2(N_IN+2)  0..N_IN-1 weight i, N_IN threshold, N_IN+1 refractory period
- cfg_data  in  STATE_W  write data; weights take low W_W bits
- state  out  STATE_W  membrane state register
- v_out  out  1  spike, one-cycle registered pulse
- refractory  out  1  high while refractory counter nonzero

Behaviour:
- Reset (sync, on clk edge with reset=1), reset dominates en/cfg_we:
  - state=0, v_out=0, refractory=0, refractory counter=0
  - all weights=+1, threshold=2^(STATE_W-1), refrac_period=REFRAC_DEF
- en=0: state, counter and v_out=0 held (v_out deasserts); config writes still accepted.
- Step with en=1 and counter>0:
  - counter decrements; state forced 0; no integration; v_out=0
  - refractory = (counter after update != 0)
- Step with en=1 and counter=0:
  - sum = Σ v_in_i (zero-extended) * w_i (sign-extended), in signed ACC_W = STATE_W+IN_W+W_W+$clog2(N_IN)+2 bits
  - next = state - (state>>LEAK_SHIFT) + sum
  - next saturated to [0, 2^STATE_W-1]
  - if saturated next >= threshold: state<=0, v_out<=1, counter<=refrac_period, refractory<=(refrac_period!=0); else state<=next, v_out<=0
- Latency: v_out and state are registered, one cycle after the sampling edge; no combinational path from inputs to outputs.
- threshold=0: every non-refractory step fires.
- refrac_period=0: may fire on consecutive steps.
- Config write and step in the same cycle: the step uses the old register values; the new value is effective from the next edge. A write to refrac_period does not alter a running counter.
- cfg_addr > N_IN+1: write ignored.

Decomposition:
- Package neuron_pkg:
  - ACC_W width function
  - cfg address constants (CFG_THRESH, CFG_REFRAC as offsets from N_IN)
  - saturate_u function (signed ACC_W to unsigned STATE_W clamp)
- Sub-module neuron_weighted_sum (combinational): N_IN MACs plus adder tree, parameters N_IN/IN_W/W_W, output signed ACC_W.
- Top keeps the config regfile, leak/saturate/threshold and the refractory FSM (INTEGRATE / REFRACTORY, implied by counter==0).

Test Plan (defaults N_IN=2, IN_W=4, W_W=4, STATE_W=8, LEAK_SHIFT=1, REFRAC_DEF=2):
- Reset with en=1 and v_in=0xFF -> state=0, v_out=0, refractory=0 on all cycles while reset high.
- Default weights, v_in both 15, en=1 -> state 30,45,53,57,59,60,60 then holds; no spike. Then write threshold=50 -> next step v_out=1, state=0.
- Weights 7/7, v_in 15/15 -> step1 sum 210 ≥128: v_out=1, state=0. Next 2 steps refractory=1, state=0. Fires again on step4; period 3 cycles. With en toggling 1/0, spike spacing counts only en=1 cycles.
- Weights -8/-8, v_in 15/15 -> state stays 0 (low saturation), never spikes. Threshold=255 with weights 7/7 -> 0, 210, then 315 saturates to 255 and fires.
- Write refrac_period=0, threshold=0 -> v_out=1 on every en cycle. Config write with simultaneous step -> old threshold used on that step.
- Reset asserted mid-refractory (counter=2) -> next cycle counter=0, refractory=0. Weights back to +1: v_in 15/15 gives state 30 on the first step.
